vga_scanout: RTL and testbench

//   Next-generation VGA scan-out engine: parametrised timing generator plus in-order framebuffer

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_prefetch_fifo.sv | 56 +++++
 rtl/vga_scanout.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan-out engine: timing totals, RGB444 field layout,
// pixel type and the resync FSM states.
package vga_pkg;

  localparam int PIXEL_BITS = 12;
  localparam int RED_MSB    = 11;
  localparam int GREEN_MSB  = 7;
  localparam int BLUE_MSB   = 3;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_RESYNC_WAIT = 2'd1,
    ST_DRAIN       = 2'd2
  } resync_state_t;

  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // Totals for the default 640x480 mode.
  localparam int H_TOTAL = timing_total(640, 16, 96, 48);
  localparam int V_TOTAL = timing_total(480, 10, 2, 33);

endpackage

// File: rtl/vga_prefetch_fifo.sv
// Synchronous prefetch FIFO holding RGB444 pixels ahead of the beam.
// Flush empties it in one cycle and wins over a simultaneous push or pop.
module vga_prefetch_fifo
  import vga_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  pixel_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output pixel_t        head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count decide which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: registers use non-blocking assignment so every update sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out engine: timing generator, in-order framebuffer prefetch and underrun resync.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_pattern input showing 8 colour bars.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int RED_BITS     = 3,
  parameter int GREEN_BITS   = 3,
  parameter int BLUE_BITS    = 3,
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int ADDRESS_BITS = 22,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                    test_pattern,
`endif
  output logic                    hsync,
  output logic                    vsync,
  output logic [RED_BITS-1:0]     red,
  output logic [GREEN_BITS-1:0]   green,
  output logic [BLUE_BITS-1:0]    blue,
  output logic                    active,
  output logic                    frame_start,
  output logic                    read_request,
  output logic [ADDRESS_BITS-1:0] read_address,
  input  logic                    read_valid,
  input  pixel_t                  pixel_data,
  output logic                    underrun
);

  localparam int LINE_CYCLES = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int FRAME_LINES = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int HW          = $clog2(LINE_CYCLES);
  localparam int VW          = $clog2(FRAME_LINES);
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_CYCLES - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(FRAME_LINES - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [ADDRESS_BITS-1:0] ADDR_LAST = ADDRESS_BITS'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

  logic [HW-1:0]           h;
  logic [VW-1:0]           v;
  logic [ADDRESS_BITS-1:0] addr;
  logic [CW-1:0]           outstanding;
  resync_state_t           state;
  resync_state_t           state_next;

  logic                    visible;
  logic                    in_hsync;
  logic                    in_vsync;
  logic                    vsync_first;
  logic                    tp_on;
  logic                    response;
  logic                    fetch_ok;
  logic                    flush;
  logic                    drain;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    starve;
  logic                    credit_ok;

  pixel_t                  fifo_head;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;

  logic [RED_BITS-1:0]     red_c;
  logic [GREEN_BITS-1:0]   green_c;
  logic [BLUE_BITS-1:0]    blue_c;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_WIDTH = HW'(H_ACTIVE / 8);
  logic [2:0] bar;
  assign tp_on = test_pattern;
  assign bar   = 3'(h / BAR_WIDTH);
`else
  assign tp_on = 1'b0;
`endif

  // Beam position decode; sync windows and the visible area read the current counters.
  assign visible     = enable && (h < H_VIS_END) && (v < V_VIS_END);
  assign in_hsync    = enable && (h >= HS_FIRST) && (h <= HS_LAST);
  assign in_vsync    = enable && (v >= VS_FIRST) && (v <= VS_LAST);
  assign vsync_first = enable && (h == '0) && (v == VS_FIRST);

  // Credit counts requests still in flight, so the FIFO can never be pushed past full.
  assign credit_ok = (({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT_LIMIT);
  assign response  = read_valid && (outstanding != '0);
  assign issue     = enable && fetch_ok && !tp_on && credit_ok;
  assign push      = response && !flush && !drain && !fifo_full;
  assign pop       = visible && !tp_on && !fifo_empty;
  assign starve    = visible && !tp_on && fifo_empty;

  vga_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (pixel_data),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:         if (starve)            state_next = ST_RESYNC_WAIT;
      ST_RESYNC_WAIT: if (vsync_first)       state_next = ST_DRAIN;
      ST_DRAIN:       if (outstanding == '0) state_next = ST_RUN;
      default:                               state_next = ST_RUN;
    endcase
  end

  always_comb begin
    fetch_ok = 1'b0;
    flush    = 1'b0;
    drain    = 1'b0;
    unique case (state)
      ST_RUN:         fetch_ok = 1'b1;
      ST_RESYNC_WAIT: flush    = vsync_first;
      ST_DRAIN:       drain    = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr         <= '0;
      outstanding  <= '0;
      read_request <= 1'b0;
      read_address <= '0;
    end else begin
      read_request <= issue;
      if (issue) read_address <= addr;
      if (flush)      addr <= '0;
      else if (issue) addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
      case ({issue, response})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    red_c   = '0;
    green_c = '0;
    blue_c  = '0;
    if (visible) begin
`ifdef VGA_TEST_PATTERN_EN
      if (tp_on) begin
        red_c   = {RED_BITS{bar[2]}};
        green_c = {GREEN_BITS{bar[1]}};
        blue_c  = {BLUE_BITS{bar[0]}};
      end else
`endif
      if (pop) begin
        red_c   = fifo_head[RED_MSB   -: RED_BITS];
        green_c = fifo_head[GREEN_MSB -: GREEN_BITS];
        blue_c  = fifo_head[BLUE_MSB  -: BLUE_BITS];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
      red         <= red_c;
      green       <= green_c;
      blue        <= blue_c;
      active      <= visible;
      frame_start <= visible && (h == '0) && (v == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       underrun <= 1'b0;
    else if (starve) underrun <= 1'b1;
  end

  // Low colour bits of each RGB444 field are dropped when the output is narrower.
  logic unused_bits;
  assign unused_bits = ^fifo_head;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout at a reduced 8x4 timing: a queue-based reference model
// predicts every registered output while a behavioural memory answers requests in order.
module tb_vga_scanout;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DEPTH = 4;
  localparam int AB = 8;
  localparam int RB = 4, GB = 3, BB = 2;
  localparam int NPIX = HA * VA;
  localparam bit HSP = 1'b0, VSP = 1'b1;
  localparam int P_RUN = 0, P_WAIT = 1, P_DRAIN = 2;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          test_pattern;
  logic          hsync, vsync, active, frame_start, read_request, underrun;
  logic [RB-1:0] red;
  logic [GB-1:0] green;
  logic [BB-1:0] blue;
  logic [AB-1:0] read_address;
  logic          read_valid;
  logic [11:0]   pixel_data;

  vga_scanout #(
    .RED_BITS(RB), .GREEN_BITS(GB), .BLUE_BITS(BB),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HSP), .VSYNC_POL(VSP),
    .ADDRESS_BITS(AB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .hsync        (hsync),
    .vsync        (vsync),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .active       (active),
    .frame_start  (frame_start),
    .read_request (read_request),
    .read_address (read_address),
    .read_valid   (read_valid),
    .pixel_data   (pixel_data),
    .underrun     (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Framebuffer contents and in-order memory with per-request latency.
  typedef struct {int addr; int due;} req_t;
  logic [11:0] pix_mem [NPIX];
  req_t        pend [$];
  int          lat  = 1;
  bit          hold = 1'b0;
  int          cyc  = 0;

  // Reference model: beam position as a linear index, FIFO as a queue.
  int          m_pos, m_out, m_addr, m_phase;
  bit          m_under;
  logic [11:0] m_q [$];
  logic        e_hs, e_vs, e_active, e_fs, e_req, e_under;
  logic [3:0]  e_red, e_green, e_blue;
  int          e_addr;

  task automatic model_step(input bit rst, input bit en, input bit rv,
                            input logic [11:0] data, input bit tp);
    int h, v, k;
    bit vis, resp, vs0, flush, drain, starve, issue;
    logic [11:0] head;
    if (rst) begin
      m_pos = 0; m_out = 0; m_addr = 0; m_phase = P_RUN; m_under = 0; m_q.delete();
      e_hs = !HSP; e_vs = !VSP; e_active = 0; e_fs = 0; e_req = 0; e_under = 0;
      e_red = 0; e_green = 0; e_blue = 0; e_addr = 0;
      return;
    end
    h      = m_pos % HT;
    v      = m_pos / HT;
    vis    = en && h < HA && v < VA;
    resp   = rv && m_out > 0;
    vs0    = en && m_pos == (VA + VF) * HT;
    flush  = (m_phase == P_WAIT) && vs0;
    drain  = (m_phase == P_DRAIN);
    starve = vis && !tp && m_q.size() == 0;
    issue  = en && m_phase == P_RUN && !tp && (m_q.size() + m_out < DEPTH);

    e_red = 0; e_green = 0; e_blue = 0;
    if (vis && tp) begin
      k       = h / (HA / 8);
      e_red   = k[2] ? (1 << RB) - 1 : 0;
      e_green = k[1] ? (1 << GB) - 1 : 0;
      e_blue  = k[0] ? (1 << BB) - 1 : 0;
    end else if (vis && m_q.size() > 0) begin
      head    = m_q.pop_front();
      e_red   = head[11:8] >> (4 - RB);
      e_green = head[7:4]  >> (4 - GB);
      e_blue  = head[3:0]  >> (4 - BB);
    end
    e_active = vis;
    e_hs     = (en && h >= HA + HF && h < HA + HF + HS) ? HSP : !HSP;
    e_vs     = (en && v >= VA + VF && v < VA + VF + VS) ? VSP : !VSP;
    e_fs     = vis && m_pos == 0;
    e_req    = issue;
    if (issue) e_addr = m_addr;

    if (flush) m_q.delete();
    if (resp && !flush && !drain) m_q.push_back(data);
    case (m_phase)
      P_RUN:   if (starve)     m_phase = P_WAIT;
      P_WAIT:  if (vs0)        m_phase = P_DRAIN;
      default: if (m_out == 0) m_phase = P_RUN;
    endcase
    m_out = m_out + int'(issue) - int'(resp);
    if (flush)      m_addr = 0;
    else if (issue) m_addr = (m_addr + 1) % NPIX;
    if (starve) m_under = 1;
    e_under = m_under;
    m_pos   = en ? (m_pos + 1) % (HT * VT) : 0;
  endtask

  // One clock: compare outputs mid-cycle, run the memory, drive inputs for the next edge.
  task automatic cycle(input bit rst, input bit en, input bit tp);
    req_t r;
    @(negedge clock);
    check("hsync",        hsync,        e_hs);
    check("vsync",        vsync,        e_vs);
    check("red",          red,          e_red);
    check("green",        green,        e_green);
    check("blue",         blue,         e_blue);
    check("active",       active,       e_active);
    check("frame_start",  frame_start,  e_fs);
    check("read_request", read_request, e_req);
    check("read_address", read_address, e_addr);
    check("underrun",     underrun,     e_under);
    if (read_request === 1'b1) pend.push_back('{addr: int'(read_address), due: cyc + lat});
    read_valid = 1'b0;
    pixel_data = 12'($urandom);
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      r          = pend.pop_front();
      read_valid = 1'b1;
      pixel_data = pix_mem[r.addr % NPIX];
    end
    reset        = rst;
    enable       = en;
    test_pattern = tp;
    model_step(rst, en, read_valid, pixel_data, tp);
    cyc++;
  endtask

  initial begin
    bit found;
    reset = 1'b1; enable = 1'b0; test_pattern = 1'b0; read_valid = 1'b0; pixel_data = '0;
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 12'($urandom);
    model_step(1, 0, 0, 0, 0);

    // Reset state, then latency-1 memory over three frames (first frame starts empty).
    repeat (3) cycle(1, 0, 0);
    lat = 1;
    repeat (3 * HT * VT) cycle(0, 1, 0);

    // Fresh start with latency-3 memory.
    repeat (2) cycle(1, 0, 0);
    lat = 3;
    repeat (3 * HT * VT) cycle(0, 1, 0);

    // Starve the FIFO mid-line, then recover through vsync resync.
    found = 0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      if (m_pos == 2 * HT + 3) found = 1;
      else cycle(0, 1, 0);
    end
    check("reach_mid_line", found, 1'b1);
    hold = 1'b1;
    repeat (20) cycle(0, 1, 0);
    hold = 1'b0;
    repeat (2 * HT * VT) cycle(0, 1, 0);

    // Reset mid-line with responses in flight; stale responses arrive while idle.
    found = 0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      if (m_out >= 2 && (m_pos % HT) < HA && (m_pos / HT) < VA) found = 1;
      else cycle(0, 1, 0);
    end
    check("reach_two_outstanding", found, 1'b1);
    cycle(1, 1, 0);
    repeat (8) cycle(0, 0, 0);
    check("stale_drained", pend.size(), 0);
    repeat (2 * HT * VT) cycle(0, 1, 0);

    // Enable dropped mid-frame for ten cycles, then restart from the origin.
    repeat (HT * 2 + 5) cycle(0, 1, 0);
    repeat (10) cycle(0, 0, 0);
    repeat (2 * HT * VT) cycle(0, 1, 0);

    // Randomised latency, response stalls and enable drops.
    for (int i = 0; i < 500; i++) begin
      lat  = int'($urandom_range(1, 4));
      hold = ($urandom_range(0, 5) == 0);
      cycle(0, $urandom_range(0, 40) != 0, 0);
    end
    hold = 1'b0;
    repeat (20) cycle(0, 1, 0);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars with fetch suppressed.
    repeat (2) cycle(1, 0, 0);
    repeat (2 * HT * VT) cycle(0, 1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
